// File: rtl/word_char_sequencer_if.sv
// Character stream from the word sequencer to the display writer.
// Handshake: a character moves on any rising clock edge where char_valid and
// char_ready are both high. While char_valid is high and char_ready is low,
// the master holds char_out and char_last unchanged. char_last marks the
// final character of the word.
interface word_char_sequencer_if #(
  parameter int CHAR_W = 4
);
  logic [CHAR_W-1:0] char_out;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;

  modport master (
    output char_out,
    output char_valid,
    output char_last,
    input  char_ready
  );

  modport slave (
    input  char_out,
    input  char_valid,
    input  char_last,
    output char_ready
  );
endinterface

// File: rtl/word_char_sequencer.sv
// word_char_sequencer: walks a word ROM one index at a time and hands each
// character downstream on a valid/ready stream, then idles for GAP_CYCLES
// before finishing the word.
// Optional feature macro WORD_SEQ_REPEAT_EN: when defined, the word repeats
// after the gap (re-reading rom_len) until stop; done never pulses.
// state_dbg exposes the FSM state (0 IDLE, 1 FETCH, 2 SEND, 3 GAP).
module word_char_sequencer #(
  parameter int CHAR_W     = 4,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  output logic [IDX_W-1:0]      rom_index,
  input  logic [CHAR_W-1:0]     rom_char,
  input  logic [IDX_W-1:0]      rom_len,
  word_char_sequencer_if.master chr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Counter must be able to hold GAP_CYCLES itself (terminal value).
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

  state_t            state;
  logic [IDX_W-1:0]  len_lat;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CHAR_W-1:0] out_code;
  logic              out_valid;
  logic              out_last;

  assign chr.char_out   = out_code;
  assign chr.char_valid = out_valid;
  assign chr.char_last  = out_last;
  assign state_dbg      = state;

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rom_index <= '0;
      out_code  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_lat   <= '0;
      gap_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a transfer on this edge.
        // A character accepted on this edge is not resent.
        state     <= IDLE;
        rom_index <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
        gap_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            rom_index <= '0;
            if (start) begin
              if (rom_len != '0) begin
                len_lat <= rom_len;
                state   <= FETCH;
                busy    <= 1'b1;
              end else begin
                // Empty word: finish immediately without touching the stream.
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            // rom_index has been stable for a full cycle; capture the code.
            out_code  <= rom_char;
            out_last  <= (rom_index == len_lat - IDX_W'(1));
            out_valid <= 1'b1;
            state     <= SEND;
          end
          SEND: begin
            if (out_valid && chr.char_ready) begin
              out_valid <= 1'b0;
              if (out_last) begin
                rom_index <= '0;
                gap_cnt   <= '0;
                state     <= GAP;
              end else begin
                rom_index <= rom_index + IDX_W'(1);
                state     <= FETCH;
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_MAX) begin
              gap_cnt <= '0;
`ifdef WORD_SEQ_REPEAT_EN
              // Restart the word from index 0 with a fresh length.
              rom_index <= '0;
              if (rom_len != '0) begin
                len_lat <= rom_len;
                state   <= FETCH;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
`else
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_char_sequencer.sv
// Directed testbench for word_char_sequencer: a combinational ROM model, a
// stream monitor checking transfers against an expected queue, and a final
// summary line.
module tb_word_char_sequencer;
  localparam int CHAR_W     = 4;
  localparam int IDX_W      = 4;
  localparam int GAP_CYCLES = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  logic start;
  logic stop;
  logic [IDX_W-1:0]  rom_index;
  logic [CHAR_W-1:0] rom_char;
  logic [IDX_W-1:0]  rom_len;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  always #5 clock = ~clock;

  word_char_sequencer_if #(.CHAR_W(CHAR_W)) chr ();

  word_char_sequencer #(
    .CHAR_W(CHAR_W),
    .IDX_W(IDX_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stop(stop),
    .rom_index(rom_index),
    .rom_char(rom_char),
    .rom_len(rom_len),
    .chr(chr),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // Combinational word ROM model.
  logic [CHAR_W-1:0] word_mem [16];
  assign rom_char = word_mem[rom_index];

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [CHAR_W:0] exp_q[$];
  logic [CHAR_W:0] e;
  int xfer_cnt = 0;
  int first_xfer_edge = 0;
  int last_xfer_edge = 0;
  int xfer_edge [64];
  int done_cnt = 0;
  int done_edge = 0;
  int start_edge = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [CHAR_W:0] prev_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: looks at the stream mid-cycle; a transfer seen here completes
  // on the next rising edge (edge number cyc+1).
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_valid", chr.char_valid, 1);
        check("stall_data", {chr.char_last, chr.char_out}, prev_word);
      end
      if (chr.char_valid && chr.char_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_xfer", {chr.char_last, chr.char_out}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("xfer", {chr.char_last, chr.char_out}, e);
        end
        if (xfer_cnt == 0) first_xfer_edge = cyc + 1;
        if (chr.char_last) last_xfer_edge = cyc + 1;
        if (xfer_cnt < 64) xfer_edge[xfer_cnt] = cyc + 1;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
        check("done_idle", busy, 0);
      end
      prev_valid = chr.char_valid;
      prev_ready = chr.char_ready;
      prev_word  = {chr.char_last, chr.char_out};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic load_word11();
    logic [CHAR_W-1:0] codes [11];
    codes = '{4'd1, 4'd7, 4'd6, 4'd8, 4'd9, 4'd7, 4'd6, 4'd3, 4'd10, 4'd4, 4'd2};
    for (int i = 0; i < 11; i++) word_mem[i] = codes[i];
    rom_len = 4'd11;
  endtask

  task automatic push_word11(input int count);
    logic [CHAR_W-1:0] codes [11];
    codes = '{4'd1, 4'd7, 4'd6, 4'd8, 4'd9, 4'd7, 4'd6, 4'd3, 4'd10, 4'd4, 4'd2};
    for (int i = 0; i < count; i++) exp_q.push_back({(i == 10) ? 1'b1 : 1'b0, codes[i]});
  endtask

  // Wait for one done pulse; mode 1 gives char_ready high one cycle in three.
  task automatic wait_done(input int budget, input int ready_mode);
    int base;
    base = done_cnt;
    for (int k = 0; k < budget; k++) begin
      if (ready_mode == 1) chr.char_ready = (k % 3 == 2);
      tick();
      if (done_cnt != base) break;
    end
    check("done_seen", done_cnt - base, 1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (xfer_cnt >= n) break;
      tick();
    end
    check("xfer_count", xfer_cnt, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_done;
    for (int i = 0; i < 16; i++) word_mem[i] = '0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    rom_len = '0;
    chr.char_ready = 1'b0;
    #12;
    check("rst_index", rom_index, 0);
    check("rst_char", chr.char_out, 0);
    check("rst_valid", chr.char_valid, 0);
    check("rst_last", chr.char_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();

`ifndef WORD_SEQ_REPEAT_EN
    // 11-character word, downstream always ready.
    load_word11();
    push_word11(11);
    xfer_cnt = 0;
    chr.char_ready = 1'b1;
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done(200, 0);
    check("first_latency", first_xfer_edge - start_edge, 2);
    check("done_delay", done_edge - last_xfer_edge, GAP_CYCLES + 1);
    check("word11_count", xfer_cnt, 11);
    check("word11_queue", exp_q.size(), 0);
    check("word11_index", rom_index, 0);
    tick();
    check("done_one_cycle", done, 0);

    // Same word with a stalling downstream.
    push_word11(11);
    xfer_cnt = 0;
    chr.char_ready = 1'b0;
    pulse_start();
    wait_done(300, 1);
    check("stall_count", xfer_cnt, 11);
    check("stall_queue", exp_q.size(), 0);
    chr.char_ready = 1'b1;
    tick();

    // Empty word: done next cycle, nothing on the stream.
    rom_len = 4'd0;
    xfer_cnt = 0;
    pulse_start();
    check("len0_done", done, 1);
    check("len0_valid", chr.char_valid, 0);
    check("len0_busy", busy, 0);
    tick();
    check("len0_done_drop", done, 0);
    check("len0_xfers", xfer_cnt, 0);

    // Single-character word.
    word_mem[0] = 4'd5;
    rom_len = 4'd1;
    exp_q.push_back({1'b1, 4'd5});
    xfer_cnt = 0;
    pulse_start();
    wait_done(100, 0);
    check("len1_count", xfer_cnt, 1);
    check("len1_done_delay", done_edge - last_xfer_edge, GAP_CYCLES + 1);
`else
    // Repeating 3-character word.
    word_mem[0] = 4'd1;
    word_mem[1] = 4'd7;
    word_mem[2] = 4'd6;
    rom_len = 4'd3;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({1'b0, 4'd1});
      exp_q.push_back({1'b0, 4'd7});
      exp_q.push_back({1'b1, 4'd6});
    end
    xfer_cnt = 0;
    base_done = done_cnt;
    chr.char_ready = 1'b1;
    pulse_start();
    wait_xfers(6, 100);
    check("rep_gap", xfer_edge[3] - xfer_edge[2], GAP_CYCLES + 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("rep_stop_busy", busy, 0);
    check("rep_no_done", done_cnt - base_done, 0);
    exp_q.push_back({1'b0, 4'd1});
    xfer_cnt = 0;
    pulse_start();
    wait_xfers(1, 20);
    check("rep_restart_latency", first_xfer_edge - start_edge, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
`endif

    // Stop during the 5th SEND while the 5th transfer is accepted.
    load_word11();
    exp_q.delete();
    push_word11(5);
    xfer_cnt = 0;
    chr.char_ready = 1'b1;
    base_done = done_cnt;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      tick();
      if (xfer_cnt == 4 && chr.char_valid) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        break;
      end
    end
    check("stop_busy", busy, 0);
    check("stop_index", rom_index, 0);
    check("stop_valid", chr.char_valid, 0);
    check("stop_state", state_dbg, 0);
    check("stop_xfers", xfer_cnt, 5);
    for (int k = 0; k < 20; k++) tick();
    check("stop_no_done", done_cnt - base_done, 0);
    check("stop_xfers_after", xfer_cnt, 5);
    check("stop_queue", exp_q.size(), 0);

    // Asynchronous reset while a character is waiting in SEND.
    load_word11();
    chr.char_ready = 1'b0;
    pulse_start();
    tick();
    check("pre_reset_valid", chr.char_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", chr.char_valid, 0);
    check("areset_char", chr.char_out, 0);
    check("areset_busy", busy, 0);
    check("areset_state", state_dbg, 0);
    check("areset_index", rom_index, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_valid", chr.char_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/word_char_sequencer.md
Name: word_char_sequencer

Overview:
- Drives the character index into a word ROM and reads back the character code plus word length.
- Latches each code and presents it to the downstream display writer on a valid/ready handshake, one character per transfer, in index order.
- Sits between the top-level control (start/stop) and the word ROM + display driver.
- Replaces the free-running index counter with a handshaked, length-aware sequencer.

Parameters:
- CHAR_W, 4, width of character code from the ROM and to the display
- IDX_W, 4, width of the character index and length
- GAP_CYCLES, 8, idle cycles inserted after the last character before a repeat or done (0 allowed)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a word when in IDLE, ignored otherwise
- stop  input  1  abort; returns to IDLE at the next edge from any state
- rom_index  output  IDX_W  character index to the word ROM
- rom_char  input  CHAR_W  ROM code for rom_index (combinational ROM)
- rom_len  input  IDX_W  word length from the ROM
- char_out  output  CHAR_W  registered character presented downstream
- char_valid  output  1  char_out is valid
- char_ready  input  1  downstream accepts char_out
- char_last  output  1  qualifies char_out as the final character of the word
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a word completes, not repeating

Behaviour:
- Reset (async, immediate): state=IDLE, rom_index=0, char_out=0, char_valid=0, char_last=0, busy=0, done=0, len_lat=0, gap counter=0.
- States and transitions:
  - IDLE: rom_index=0.
    - start=1 and rom_len!=0: latch len_lat=rom_len, go to FETCH.
    - start=1 and rom_len==0: pulse done next cycle, stay IDLE.
  - FETCH: one cycle with rom_index stable. At the edge, char_out<=rom_char, char_last<=(rom_index==len_lat-1), char_valid<=1, go to SEND.
  - SEND: char_valid held high; char_out and char_last stable until accepted.
    - Transfer occurs on an edge with char_valid&char_ready; char_valid<=0.
    - If not last: rom_index<=rom_index+1, go to FETCH.
    - If last: rom_index<=0, go to GAP.
    - char_ready low: stay in SEND indefinitely, no timeout.
  - GAP: count GAP_CYCLES cycles, then end of word (see Optional Feature). GAP_CYCLES=0 means exit on the first GAP cycle.
- Latency:
  - start at edge N gives FETCH at N, and char_valid=1 after edge N+1.
  - With char_ready tied high, one character per 2 cycles.
- len_lat is frozen for the whole word; rom_len changes mid-word are ignored.
- rom_len=15 gives indices 0..14. rom_index never exceeds len_lat-1.
- stop has priority over every other event, including a same-cycle transfer:
  - Next state is IDLE, char_valid=0, rom_index=0, no done.
  - An accepted transfer in that cycle still counts downstream; the sequencer does not resend.
- start while busy is ignored. start and stop in the same cycle in IDLE: stop wins, stay IDLE.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: WORD_SEQ_REPEAT_EN.
- Defined: at GAP end, return to FETCH with rom_index=0 and re-latch len_lat=rom_len. The word repeats until stop. done never pulses; if the re-latched rom_len==0, go to IDLE instead.
- Undefined: at GAP end, go to IDLE and pulse done for one cycle.

Test Plan:
- Reset mid-SEND with char_valid=1 -> all outputs 0 immediately, IDLE, busy=0.
- ROM model len=11, codes 1,7,6,8,9,7,6,3,10,4,2, char_ready=1, start pulse -> 11 transfers in that order. char_last only on code 2. busy high through GAP; done pulse GAP_CYCLES+1 cycles after the last transfer (feature off).
- Same word, char_ready toggled 1-in-3 -> identical sequence. char_out and char_valid stable during every stall; no skipped or duplicated index.
- rom_len=0 with start -> no char_valid, done pulse next cycle; rom_len=1 -> single transfer with char_last=1.
- stop asserted during the 5th SEND with char_ready=1 same cycle -> 5 transfers total, IDLE next cycle, rom_index=0, no done.
- WORD_SEQ_REPEAT_EN defined, len=3, codes 1,7,6 -> repeating 1,7,6 separated by GAP_CYCLES idle cycles, no done. stop terminates; second start restarts at index 0.
